// File: rtl/oric_ram_bridge.sv
// Bridges the Oric core's strobe-driven 8-bit RAM bus onto a toggle-handshake
// 16-bit SDRAM port, with a one-deep pending slot and an ack watchdog.
module oric_ram_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    output logic [7:0]  ram_q,
    output logic        port_req,
    input  logic        port_ack,
    output logic [15:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    output logic [15:0] port_d,
    input  logic [15:0] port_q,
    output logic        busy,
    output logic        err,
    output logic        ovf
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state;

    logic [1:0]     cs_s, oe_s, we_s;
    logic           rd_lvl, wr_lvl, rd_lvl_d, wr_lvl_d;
    logic           rd_ev, wr_ev, ad_ev, any_ev;
    logic           ev_q;
    logic [15:0]    cap_ad;
    logic [7:0]     cap_d;
    logic           cap_we;
    logic           pend_valid;
    logic [15:0]    pend_ad;
    logic [7:0]     pend_d;
    logic           pend_we;
    logic           ack_d, ack_edge;
    logic [WDW-1:0] wdog;
    logic           issue_en, issue_pend, store_ev;
    logic [15:0]    issue_ad;
    logic [7:0]     issue_d;
    logic           issue_we;

    assign rd_lvl   = cs_s[1] & oe_s[1];
    assign wr_lvl   = cs_s[1] & we_s[1];
    assign rd_ev    = rd_lvl & ~rd_lvl_d;
    assign wr_ev    = wr_lvl & ~wr_lvl_d;
    assign ad_ev    = rd_lvl & (ram_ad != cap_ad);
    assign any_ev   = rd_ev | wr_ev | ad_ev;
    assign ack_edge = port_ack ^ ack_d;
    assign busy     = (state != IDLE) | pend_valid;

    // Strobe synchronisers and registered event detection; cap_ad doubles as
    // the last-detected address so a held read re-fires when the address moves.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cs_s     <= '0;
            oe_s     <= '0;
            we_s     <= '0;
            rd_lvl_d <= 1'b0;
            wr_lvl_d <= 1'b0;
            ev_q     <= 1'b0;
            cap_ad   <= '0;
            cap_d    <= '0;
            cap_we   <= 1'b0;
        end else begin
            cs_s     <= {cs_s[0], ram_cs};
            oe_s     <= {oe_s[0], ram_oe};
            we_s     <= {we_s[0], ram_we};
            rd_lvl_d <= rd_lvl;
            wr_lvl_d <= wr_lvl;
            ev_q     <= any_ev;
            if (any_ev) begin
                cap_ad <= ram_ad;
                cap_d  <= ram_d;
                cap_we <= wr_lvl;
            end
        end
    end

    always_comb begin
        issue_en   = 1'b0;
        issue_pend = 1'b0;
        case (state)
            IDLE: begin
                issue_en   = pend_valid | ev_q;
                issue_pend = pend_valid;
            end
            DONE: begin
                issue_en   = pend_valid;
                issue_pend = pend_valid;
            end
            default: ;
        endcase
        issue_ad = issue_pend ? pend_ad : cap_ad;
        issue_d  = issue_pend ? pend_d  : cap_d;
        issue_we = issue_pend ? pend_we : cap_we;
        store_ev = ev_q & ~(issue_en & ~issue_pend);
    end

    // Request FSM: issue, wait for an ack edge or the watchdog, one DONE cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            ram_q      <= 8'h00;
            port_req   <= 1'b0;
            port_a     <= '0;
            port_ds    <= 2'b11;
            port_we    <= 1'b0;
            port_d     <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            ack_d      <= 1'b0;
            wdog       <= '0;
            pend_valid <= 1'b0;
            pend_ad    <= '0;
            pend_d     <= '0;
            pend_we    <= 1'b0;
        end else begin
            ack_d <= port_ack;

            if (store_ev) begin
                pend_valid <= 1'b1;
                pend_ad    <= cap_ad;
                pend_d     <= cap_d;
                pend_we    <= cap_we;
                if (pend_valid && !issue_pend)
                    ovf <= 1'b1;
            end else if (issue_pend) begin
                pend_valid <= 1'b0;
            end

            if (issue_en) begin
                port_a   <= issue_ad;
                port_we  <= issue_we;
                port_d   <= {issue_d, issue_d};
                port_ds  <= issue_we ? (issue_ad[0] ? 2'b10 : 2'b01) : 2'b11;
                port_req <= ~port_req;
                wdog     <= '0;
                state    <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (ack_edge) begin
                            if (!port_we)
                                ram_q <= port_a[0] ? port_q[15:8] : port_q[7:0];
                            state <= DONE;
                        end else if (wdog == WD_LIMIT) begin
                            err <= 1'b1;
                            if (!port_we)
                                ram_q <= 8'hFF;
                            state <= DONE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oric_ram_bridge.sv
// Directed bench for oric_ram_bridge: reset, read/write steering, address
// stepping, pending overflow, watchdog timeout and reset mid-request.
module tb_oric_ram_bridge;
    logic        clk = 1'b0;
    logic        res_n;
    logic        ram_cs, ram_oe, ram_we;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic        port_req, port_ack;
    logic [15:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q;
    logic        busy, err, ovf;

    int   n_checks = 0;
    int   n_pass = 0;
    logic exp_req = 1'b0;

    oric_ram_bridge #(.TIMEOUT(255)) dut (
        .clk(clk), .res_n(res_n),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_ad(ram_ad), .ram_d(ram_d), .ram_q(ram_q),
        .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
        .port_ds(port_ds), .port_we(port_we), .port_d(port_d), .port_q(port_q),
        .busy(busy), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        ram_we = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
        ram_ad = '0; ram_d = '0; port_ack = 1'b0; port_q = '0;
        tick(3);
        n_checks++; if (ram_q !== 8'h00) $display("[TB] FAIL rst_ram_q: got %h exp 00", ram_q); else n_pass++;
        n_checks++; if (port_req !== 1'b0) $display("[TB] FAIL rst_req: got %b exp 0", port_req); else n_pass++;
        n_checks++; if (port_a !== 16'h0000) $display("[TB] FAIL rst_port_a: got %h exp 0000", port_a); else n_pass++;
        n_checks++; if (port_ds !== 2'b11) $display("[TB] FAIL rst_port_ds: got %b exp 11", port_ds); else n_pass++;
        n_checks++; if (port_we !== 1'b0) $display("[TB] FAIL rst_port_we: got %b exp 0", port_we); else n_pass++;
        n_checks++; if (port_d !== 16'h0000) $display("[TB] FAIL rst_port_d: got %h exp 0000", port_d); else n_pass++;
        n_checks++; if ({busy, err, ovf} !== 3'b000) $display("[TB] FAIL rst_flags: got %b exp 000", {busy, err, ovf}); else n_pass++;
        res_n = 1'b1;
        tick(2);
    endtask

    task automatic test_read();
        ram_ad = 16'h1235; ram_cs = 1'b1; ram_oe = 1'b1;
        tick(3);
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL rd_early_req: got %b exp %b", port_req, exp_req); else n_pass++;
        tick(1);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL rd_req: got %b exp %b", port_req, exp_req); else n_pass++;
        n_checks++; if (port_ds !== 2'b11) $display("[TB] FAIL rd_ds: got %b exp 11", port_ds); else n_pass++;
        n_checks++; if (port_a !== 16'h1235 || port_we !== 1'b0) $display("[TB] FAIL rd_addr: got %h/%b exp 1235/0", port_a, port_we); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL rd_busy: got %b exp 1", busy); else n_pass++;
        tick(4);
        port_q = 16'hAB12; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'hAB) $display("[TB] FAIL rd_ram_q: got %h exp AB", ram_q); else n_pass++;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rd_busy_fall: got %b exp 0", busy); else n_pass++;
        release_bus();
    endtask

    task automatic test_write();
        ram_ad = 16'h0400; ram_d = 8'h5A; ram_cs = 1'b1; ram_we = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL wr_req: got %b exp %b", port_req, exp_req); else n_pass++;
        n_checks++; if (port_we !== 1'b1) $display("[TB] FAIL wr_we: got %b exp 1", port_we); else n_pass++;
        n_checks++; if (port_ds !== 2'b01) $display("[TB] FAIL wr_ds: got %b exp 01", port_ds); else n_pass++;
        n_checks++; if (port_d !== 16'h5A5A) $display("[TB] FAIL wr_d: got %h exp 5A5A", port_d); else n_pass++;
        n_checks++; if (port_a !== 16'h0400) $display("[TB] FAIL wr_a: got %h exp 0400", port_a); else n_pass++;
        port_q = 16'hFFFF; port_ack = ~port_ack;
        tick(2);
        n_checks++; if (ram_q !== 8'hAB) $display("[TB] FAIL wr_ram_q: got %h exp AB", ram_q); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL wr_busy: got %b exp 0", busy); else n_pass++;
        release_bus();
    endtask

    task automatic test_addr_step();
        ram_ad = 16'h0010; ram_cs = 1'b1; ram_oe = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req || port_a !== 16'h0010) $display("[TB] FAIL step1_req: got %b/%h exp %b/0010", port_req, port_a, exp_req); else n_pass++;
        ram_ad = 16'h0011;
        tick(3);
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL step_hold_req: got %b exp %b", port_req, exp_req); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL step_busy: got %b exp 1", busy); else n_pass++;
        port_q = 16'h3C77; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'h77) $display("[TB] FAIL step1_ram_q: got %h exp 77", ram_q); else n_pass++;
        tick(1);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req || port_a !== 16'h0011) $display("[TB] FAIL step2_req: got %b/%h exp %b/0011", port_req, port_a, exp_req); else n_pass++;
        port_q = 16'h9E44; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'h9E) $display("[TB] FAIL step2_ram_q: got %h exp 9E", ram_q); else n_pass++;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL step_busy_fall: got %b exp 0", busy); else n_pass++;
        release_bus();
    endtask

    task automatic test_overflow();
        ram_ad = 16'h0100; ram_d = 8'h11; ram_cs = 1'b1; ram_we = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL ovf_req1: got %b exp %b", port_req, exp_req); else n_pass++;
        ram_we = 1'b0; tick(3);
        ram_ad = 16'h0200; ram_d = 8'h22; ram_we = 1'b1; tick(4);
        n_checks++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_first_store: got %b exp 0", ovf); else n_pass++;
        ram_we = 1'b0; tick(3);
        ram_ad = 16'h0201; ram_d = 8'h33; ram_we = 1'b1; tick(4);
        ram_we = 1'b0; tick(3);
        ram_ad = 16'h0305; ram_oe = 1'b1; tick(4);
        n_checks++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b exp 1", ovf); else n_pass++;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL ovf_no_extra_req: got %b exp %b", port_req, exp_req); else n_pass++;
        n_checks++; if (port_a !== 16'h0100 || port_d !== 16'h1111 || port_we !== 1'b1) $display("[TB] FAIL ovf_stable: got %h/%h/%b exp 0100/1111/1", port_a, port_d, port_we); else n_pass++;
        port_q = 16'h0000; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'h9E) $display("[TB] FAIL ovf_wr_ram_q: got %h exp 9E", ram_q); else n_pass++;
        tick(1);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req || port_a !== 16'h0305 || port_we !== 1'b0 || port_ds !== 2'b11) $display("[TB] FAIL ovf_last_issue: got %b/%h/%b/%b exp %b/0305/0/11", port_req, port_a, port_we, port_ds, exp_req); else n_pass++;
        port_q = 16'h5500; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'h55) $display("[TB] FAIL ovf_rd_ram_q: got %h exp 55", ram_q); else n_pass++;
        release_bus();
        n_checks++; if (port_req !== exp_req || busy !== 1'b0) $display("[TB] FAIL ovf_total_req: got %b/%b exp %b/0", port_req, busy, exp_req); else n_pass++;
    endtask

    task automatic test_timeout();
        ram_ad = 16'h0700; ram_cs = 1'b1; ram_oe = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL to_req: got %b exp %b", port_req, exp_req); else n_pass++;
        tick(255);
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL to_err_early: got %b exp 0", err); else n_pass++;
        tick(1);
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL to_err: got %b exp 1", err); else n_pass++;
        n_checks++; if (ram_q !== 8'hFF) $display("[TB] FAIL to_ram_q: got %h exp FF", ram_q); else n_pass++;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL to_busy: got %b exp 0", busy); else n_pass++;
        port_q = 16'h1234; port_ack = ~port_ack;
        tick(3);
        n_checks++; if (ram_q !== 8'hFF || port_req !== exp_req) $display("[TB] FAIL to_late_ack: got %h/%b exp FF/%b", ram_q, port_req, exp_req); else n_pass++;
        release_bus();
        ram_ad = 16'h0702; ram_cs = 1'b1; ram_oe = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        n_checks++; if (port_req !== exp_req) $display("[TB] FAIL to_next_req: got %b exp %b", port_req, exp_req); else n_pass++;
        port_q = 16'hC3A5; port_ack = ~port_ack;
        tick(1);
        n_checks++; if (ram_q !== 8'hA5) $display("[TB] FAIL to_next_ram_q: got %h exp A5", ram_q); else n_pass++;
        release_bus();
    endtask

    task automatic test_reset_mid();
        ram_ad = 16'h0801; ram_cs = 1'b1; ram_oe = 1'b1;
        tick(4);
        exp_req = ~exp_req;
        ram_ad = 16'h0802;
        tick(3);
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL rm_busy_pre: got %b exp 1", busy); else n_pass++;
        res_n = 1'b0; ram_cs = 1'b0; ram_oe = 1'b0;
        #2;
        exp_req = 1'b0;
        n_checks++; if (ram_q !== 8'h00) $display("[TB] FAIL rm_ram_q: got %h exp 00", ram_q); else n_pass++;
        n_checks++; if (port_req !== 1'b0 || port_a !== 16'h0000) $display("[TB] FAIL rm_req_a: got %b/%h exp 0/0000", port_req, port_a); else n_pass++;
        n_checks++; if (port_ds !== 2'b11 || port_we !== 1'b0 || port_d !== 16'h0000) $display("[TB] FAIL rm_port: got %b/%b/%h exp 11/0/0000", port_ds, port_we, port_d); else n_pass++;
        n_checks++; if ({busy, err, ovf} !== 3'b000) $display("[TB] FAIL rm_flags: got %b exp 000", {busy, err, ovf}); else n_pass++;
        tick(2);
        res_n = 1'b1;
        tick(3);
        port_q = 16'hBEEF; port_ack = ~port_ack;
        tick(3);
        n_checks++; if (ram_q !== 8'h00 || port_req !== exp_req || busy !== 1'b0) $display("[TB] FAIL rm_late_ack: got %h/%b/%b exp 00/0/0", ram_q, port_req, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_addr_step();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
